// File: rtl/i2s_rx.sv
// I2S receiver: assembles left/right words from the frame tracker's bit strobes,
// checks frame continuity and hands out stereo pairs on a valid/ready port.
module i2s_rx #(
    parameter int BITS   = 16,
    parameter int OFFSET = 1
) (
    input  logic            ck,
    input  logic            rst,
    input  logic            en,
    input  logic [5:0]      frame_posn,
    input  logic            sd,
    input  logic            ready,
    input  logic            clear_overrun,
    output logic [BITS-1:0] left,
    output logic [BITS-1:0] right,
    output logic            valid,
    output logic            overrun,
    output logic            locked,
    output logic [7:0]      err_count
);

    typedef enum logic {HUNT, RUN} state_t;

    state_t          state, state_nxt;
    logic [BITS-1:0] shreg, shreg_nxt;
    logic [BITS-1:0] hold_l, hold_l_nxt;
    logic [5:0]      prev_posn;
    logic            left_ok, left_ok_nxt;
    logic            pair_done, pair_done_nxt;
    logic            pair_cmp, sync_err, shift_en;
    logic [6:0]      rel_l, rel_r;
    logic            in_l, in_r, last_l, last_r;

    // Offsets into each channel window; positions before the window wrap to large values.
    assign rel_l  = {1'b0, frame_posn} - 7'(OFFSET);
    assign rel_r  = {1'b0, frame_posn} - 7'(32 + OFFSET);
    assign in_l   = rel_l < 7'(BITS);
    assign in_r   = rel_r < 7'(BITS);
    assign last_l = rel_l == 7'(BITS - 1);
    assign last_r = rel_r == 7'(BITS - 1);
    assign locked = (state == RUN);

    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        hold_l_nxt    = hold_l;
        left_ok_nxt   = left_ok;
        pair_done_nxt = pair_done;
        pair_cmp      = 1'b0;
        sync_err      = 1'b0;
        shift_en      = 1'b0;
        if (en) begin
            case (state)
                HUNT: begin
                    if (frame_posn == 6'd0) begin
                        state_nxt     = RUN;
                        left_ok_nxt   = 1'b0;
                        pair_done_nxt = 1'b0;
                        shift_en      = 1'b1;
                    end
                end
                RUN: begin
                    if (frame_posn != prev_posn + 6'd1 && frame_posn != 6'd0) begin
                        state_nxt     = HUNT;
                        sync_err      = 1'b1;
                        left_ok_nxt   = 1'b0;
                        pair_done_nxt = 1'b0;
                    end else begin
                        // A frame restart before the right word landed is a short frame.
                        if (frame_posn == 6'd0) begin
                            sync_err      = !pair_done;
                            left_ok_nxt   = 1'b0;
                            pair_done_nxt = 1'b0;
                        end
                        shift_en = 1'b1;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
        if (shift_en && (in_l || in_r)) begin
            shreg_nxt = BITS'({shreg, sd});
            if (in_l && last_l) begin
                hold_l_nxt  = shreg_nxt;
                left_ok_nxt = 1'b1;
            end
            if (in_r && last_r && left_ok_nxt) begin
                pair_cmp      = 1'b1;
                pair_done_nxt = 1'b1;
                left_ok_nxt   = 1'b0;
            end
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            shreg     <= '0;
            hold_l    <= '0;
            prev_posn <= '0;
            left_ok   <= 1'b0;
            pair_done <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            hold_l    <= hold_l_nxt;
            left_ok   <= left_ok_nxt;
            pair_done <= pair_done_nxt;
            if (en)
                prev_posn <= frame_posn;
            if (sync_err && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

    // Output register: a completed pair loads unless the held pair is still unaccepted.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            left    <= '0;
            right   <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (pair_cmp && (!valid || ready)) begin
                left  <= hold_l;
                right <= shreg_nxt;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (pair_cmp && valid && !ready)
                overrun <= 1'b1;
            else if (clear_overrun)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx (BITS=16, OFFSET=1): capture, backpressure,
// short frame, skip, collision, saturation and asynchronous reset.
module tb_i2s_rx;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [5:0]  frame_posn = '0;
    logic        sd = 1'b0;
    logic        ready = 1'b1;
    logic        clear_overrun = 1'b0;
    logic [15:0] left, right;
    logic        valid, overrun, locked;
    logic [7:0]  err_count;

    int          checks = 0;
    int          errors = 0;
    int          xfers = 0;
    int          clr_at = -1;
    int          rdy_at = -1;
    logic        last_vld = 1'b0;
    logic [15:0] last_l = '0, last_r = '0;

    i2s_rx #(.BITS(16), .OFFSET(1)) dut (
        .ck(ck), .rst(rst), .en(en), .frame_posn(frame_posn), .sd(sd),
        .ready(ready), .clear_overrun(clear_overrun),
        .left(left), .right(right), .valid(valid), .overrun(overrun),
        .locked(locked), .err_count(err_count)
    );

    always #5 ck = ~ck;

    always @(negedge ck) begin
        if (!rst && valid && ready) begin
            xfers  <= xfers + 1;
            last_l <= left;
            last_r <= right;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input int p, input logic b);
        @(negedge ck);
        en = 1'b1; frame_posn = 6'(p); sd = b;
        if (p == clr_at) clear_overrun = 1'b1;
        if (p == rdy_at) ready = 1'b1;
        @(negedge ck);
        en = 1'b0; clear_overrun = 1'b0;
        if (p == rdy_at) ready = 1'b0;
        last_vld = valid;
        @(negedge ck);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input int lo, input int hi, input bit pulse_chk);
        logic b;
        for (int p = lo; p <= hi; p++) begin
            b = 1'b0;
            if (p >= 1 && p <= 16)  b = l[16-p];
            if (p >= 33 && p <= 48) b = r[48-p];
            send_bit(p, b);
            if (pulse_chk && p == 48) chk("vld_pos48", last_vld, 1);
            if (pulse_chk && p == 49) chk("vld_pos49", last_vld, 0);
        end
    endtask

    initial begin
        int x0;
        repeat (3) @(negedge ck);
        chk("rst_valid", valid, 0);
        chk("rst_left", left, 0);
        chk("rst_right", right, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err_count, 0);
        rst = 1'b0;

        // Hunting: tail of a frame must not lock
        send_frame(16'hFFFF, 16'hFFFF, 40, 63, 0);
        chk("hunt_locked", locked, 0);
        chk("hunt_err", err_count, 0);

        // Normal capture
        send_frame(16'hA5C3, 16'h0F0F, 0, 63, 1);
        chk("cap1_locked", locked, 1);
        chk("cap1_xfers", xfers, 1);
        chk("cap1_left", last_l, 16'hA5C3);
        chk("cap1_right", last_r, 16'h0F0F);
        send_frame(16'hA5C3, 16'h0F0F, 0, 63, 1);
        chk("cap2_xfers", xfers, 2);
        chk("cap2_left", last_l, 16'hA5C3);
        chk("cap2_right", last_r, 16'h0F0F);

        // Backpressure
        ready = 1'b0;
        send_frame(16'hA5C3, 16'h0F0F, 0, 63, 0);
        chk("bp1_valid", valid, 1);
        chk("bp1_left", left, 16'hA5C3);
        chk("bp1_overrun", overrun, 0);
        send_frame(16'h1234, 16'h5678, 0, 63, 0);
        chk("bp2_valid", valid, 1);
        chk("bp2_left", left, 16'hA5C3);
        chk("bp2_right", right, 16'h0F0F);
        chk("bp2_overrun", overrun, 1);
        @(negedge ck); clear_overrun = 1'b1;
        @(negedge ck); clear_overrun = 1'b0;
        chk("bp_clr_overrun", overrun, 0);
        clr_at = 48;
        send_frame(16'h1234, 16'h5678, 0, 63, 0);
        clr_at = -1;
        chk("bp_setwins_overrun", overrun, 1);
        chk("bp_setwins_left", left, 16'hA5C3);
        @(negedge ck); clear_overrun = 1'b1;
        @(negedge ck); clear_overrun = 1'b0;
        chk("bp_clr2_overrun", overrun, 0);

        // Accept and complete in the same cycle
        rdy_at = 48;
        send_frame(16'h1234, 16'h5678, 0, 63, 0);
        rdy_at = -1;
        chk("col_valid", valid, 1);
        chk("col_left", left, 16'h1234);
        chk("col_right", right, 16'h5678);
        chk("col_overrun", overrun, 0);
        ready = 1'b1;
        repeat (3) @(negedge ck);
        chk("col_drain_valid", valid, 0);
        chk("col_drain_left", last_l, 16'h1234);

        // Short frame
        x0 = xfers;
        send_frame(16'hA5C3, 16'h0F0F, 0, 40, 0);
        send_frame(16'h1234, 16'h5678, 0, 63, 1);
        chk("short_xfers", xfers, x0 + 1);
        chk("short_left", last_l, 16'h1234);
        chk("short_right", last_r, 16'h5678);
        chk("short_err", err_count, 1);
        chk("short_locked", locked, 1);

        // Skip
        x0 = xfers;
        send_frame(16'hA5C3, 16'h0F0F, 0, 10, 0);
        send_bit(12, 1'b0);
        chk("skip_locked", locked, 0);
        chk("skip_err", err_count, 2);
        send_frame(16'hA5C3, 16'h0F0F, 13, 63, 0);
        chk("skip_hunt_xfers", xfers, x0);
        chk("skip_hunt_locked", locked, 0);
        send_frame(16'h5555, 16'hAAAA, 0, 63, 1);
        chk("relock_xfers", xfers, x0 + 1);
        chk("relock_left", last_l, 16'h5555);
        chk("relock_right", last_r, 16'hAAAA);
        chk("relock_locked", locked, 1);

        // err_count saturation: repeated frame restarts are short frames
        for (int i = 0; i < 300; i++) send_bit(0, 1'b0);
        chk("sat_err", err_count, 8'hFF);
        chk("sat_locked", locked, 1);

        // Asynchronous reset between edges with a pair held
        ready = 1'b0;
        send_frame(16'hA5C3, 16'h0F0F, 0, 63, 0);
        chk("pre_rst_valid", valid, 1);
        @(posedge ck); #2 rst = 1'b1;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_left", left, 0);
        chk("arst_right", right, 0);
        chk("arst_locked", locked, 0);
        chk("arst_err", err_count, 0);
        @(negedge ck); rst = 1'b0;
        send_frame(16'h0, 16'h0, 5, 63, 0);
        chk("arst_hunt_locked", locked, 0);
        send_bit(0, 1'b0);
        chk("arst_relock", locked, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
